// File: rtl/vc_merge.sv
// vc_merge: merges the class-0 and class-1 FIFOs into one word stream.
// Class 0 has priority. A burst counter bounds how many class-0 grants
// can be issued in a row while class 1 is also waiting. Reads are
// combinational; the merged output is registered two cycles after a read.
// Optional build macro: VC_MERGE_COUNT_EN adds per-class delivery counters
// and a sticky wrap flag.
module vc_merge #(
   parameter int DATA_W = 10,
   parameter int BURST  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] fifo0_data,
   input  logic              fifo0_empty,
   input  logic [DATA_W-1:0] fifo1_data,
   input  logic              fifo1_empty,
   input  logic              pause_in,
   output logic              read0,
   output logic              read1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              class_out
`ifdef VC_MERGE_COUNT_EN
   ,
   output logic [7:0]        cnt0,
   output logic [7:0]        cnt1,
   output logic              cnt_ovf
`endif
);

   typedef enum logic [1:0] {IDLE, G0, G1, PAUSE} state_t;

   localparam logic [3:0] BurstMax = 4'(BURST);

   state_t            state_q, state_d;
   logic [3:0]        burst_q, burst_d;
   logic              pending_q, pending_d;
   logic              pendingClass_q, pendingClass_d;
   logic [DATA_W-1:0] dataOut_q;
   logic              validOut_q;
   logic              classOut_q;

   // Grant selection: one read at most per cycle, none while paused or in
   // reset; the burst counter only advances when both classes are waiting.
   always_comb begin
      state_d        = state_q;
      burst_d        = burst_q;
      read0          = 1'b0;
      read1          = 1'b0;
      pending_d      = 1'b0;
      pendingClass_d = 1'b0;
      if (reset) begin
         state_d = IDLE;
      end else if (pause_in) begin
         state_d = PAUSE;
      end else if (!fifo0_empty && !fifo1_empty) begin
         if (burst_q < BurstMax) begin
            read0   = 1'b1;
            burst_d = burst_q + 4'd1;
            state_d = G0;
         end else begin
            read1   = 1'b1;
            burst_d = 4'd0;
            state_d = G1;
         end
      end else if (!fifo0_empty) begin
         read0   = 1'b1;
         state_d = G0;
      end else if (!fifo1_empty) begin
         read1   = 1'b1;
         burst_d = 4'd0;
         state_d = G1;
      end else begin
         state_d = IDLE;
      end
      pending_d      = read0 | read1;
      pendingClass_d = read1;
   end

   // State, burst count and the two-stage read-to-output pipeline. A word
   // read in one cycle is captured from the FIFO data bus at the end of the
   // next, and reset throws away anything still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         burst_q        <= 4'd0;
         pending_q      <= 1'b0;
         pendingClass_q <= 1'b0;
         dataOut_q      <= '0;
         validOut_q     <= 1'b0;
         classOut_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         burst_q        <= burst_d;
         pending_q      <= pending_d;
         pendingClass_q <= pendingClass_d;
         validOut_q     <= pending_q;
         if (pending_q) begin
            dataOut_q  <= pendingClass_q ? fifo1_data : fifo0_data;
            classOut_q <= pendingClass_q;
         end
      end
   end

   assign data_out  = dataOut_q;
   assign valid_out = validOut_q;
   assign class_out = classOut_q;

`ifdef VC_MERGE_COUNT_EN
   logic [7:0] cnt0_q;
   logic [7:0] cnt1_q;
   logic       cntOvf_q;

   // Delivery counters step together with the word appearing on valid_out;
   // the wrap flag stays set until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q   <= 8'd0;
         cnt1_q   <= 8'd0;
         cntOvf_q <= 1'b0;
      end else if (pending_q) begin
         if (pendingClass_q) begin
            cnt1_q <= cnt1_q + 8'd1;
            if (cnt1_q == 8'hFF) cntOvf_q <= 1'b1;
         end else begin
            cnt0_q <= cnt0_q + 8'd1;
            if (cnt0_q == 8'hFF) cntOvf_q <= 1'b1;
         end
      end
   end

   assign cnt0    = cnt0_q;
   assign cnt1    = cnt1_q;
   assign cnt_ovf = cntOvf_q;
`endif

endmodule

// File: tb/tb_vc_merge.sv
// Testbench for vc_merge: a behavioural FIFO pair feeds the DUT, expected
// words are queued in hand-computed order, and a monitor pops and compares
// every word the DUT presents on valid_out.
module tb_vc_merge;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] fifo0_data = '0;
   logic [9:0] fifo1_data = '0;
   logic       fifo0_empty;
   logic       fifo1_empty;
   logic       pause_in;
   logic       read0;
   logic       read1;
   logic [9:0] data_out;
   logic       valid_out;
   logic       class_out;
`ifdef VC_MERGE_COUNT_EN
   logic [7:0] cnt0;
   logic [7:0] cnt1;
   logic       cnt_ovf;
`endif

   vc_merge #(.DATA_W(10), .BURST(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .fifo0_data  (fifo0_data),
      .fifo0_empty (fifo0_empty),
      .fifo1_data  (fifo1_data),
      .fifo1_empty (fifo1_empty),
      .pause_in    (pause_in),
      .read0       (read0),
      .read1       (read1),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .class_out   (class_out)
`ifdef VC_MERGE_COUNT_EN
      ,
      .cnt0        (cnt0),
      .cnt1        (cnt1),
      .cnt_ovf     (cnt_ovf)
`endif
   );

   // Free-running clock, posedges at 5, 15, 25 ...
   always #5 clk = ~clk;

   logic [9:0]  mem0 [0:1023];
   logic [9:0]  mem1 [0:1023];
   logic [9:0]  wp0 = '0;
   logic [9:0]  wp1 = '0;
   logic [9:0]  rp0 = '0;
   logic [9:0]  rp1 = '0;
   logic [10:0] sbQ [$];

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int rd0Cnt = 0;
   int rd1Cnt = 0;
   int vCnt = 0;
   int firstRead = -1;
   int firstValid = -1;

   assign fifo0_empty = (rp0 == wp0);
   assign fifo1_empty = (rp1 == wp1);

   // FIFO model: a pop presents its word on the data bus the following cycle.
   always @(posedge clk) begin
      if (read0) begin
         fifo0_data <= mem0[rp0];
         rp0        <= rp0 + 10'd1;
      end
      if (read1) begin
         fifo1_data <= mem1[rp1];
         rp1        <= rp1 + 10'd1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Load one word into a class FIFO.
   task automatic applyStimulus(input logic cls, input logic [9:0] data);
      if (cls) begin
         mem1[wp1] = data;
         wp1       = wp1 + 10'd1;
      end else begin
         mem0[wp0] = data;
         wp0       = wp0 + 10'd1;
      end
   endtask

   task automatic expectWord(input logic cls, input logic [9:0] data);
      sbQ.push_back({cls, data});
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while ((!fifo0_empty || !fifo1_empty || sbQ.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s drain timeout: %0d words outstanding, expected 0",
                  name, sbQ.size());
      end
      repeat (3) @(negedge clk);
   endtask

   // Monitor: samples 1 ns before each posedge, counts reads, checks mutual
   // exclusion, and pops the scoreboard for every delivered word.
   always @(negedge clk) begin
      logic [10:0] expWord;
      #4;
      cycle++;
      if (!reset) begin
         if (read0) rd0Cnt++;
         if (read1) rd1Cnt++;
         if (read0 && firstRead < 0) firstRead = cycle;
         if (read0 || read1) checkOutput("read mutex", 32'(read0 && read1), 32'd0);
         if (valid_out) begin
            vCnt++;
            if (firstValid < 0) firstValid = cycle;
            if (sbQ.size() == 0) begin
               checkOutput("unexpected word", {21'd0, class_out, data_out}, 32'h7FF);
            end else begin
               expWord = sbQ.pop_front();
               checkOutput("merged word", {21'd0, class_out, data_out}, {21'd0, expWord});
            end
         end
      end
   end

   initial begin
      int r0;
      int r1;
      int v0;

      // Reset with class-0 words already waiting: no read may be issued.
      reset    = 1'b1;
      pause_in = 1'b0;
      applyStimulus(1'b0, 10'h0FF);
      applyStimulus(1'b0, 10'h0DD);
      applyStimulus(1'b0, 10'h0DD);
      applyStimulus(1'b0, 10'h0DD);
      expectWord(1'b0, 10'h0FF);
      expectWord(1'b0, 10'h0DD);
      expectWord(1'b0, 10'h0DD);
      expectWord(1'b0, 10'h0DD);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset read0", 32'(read0), 32'd0);
      checkOutput("reset read1", 32'(read1), 32'd0);
      checkOutput("reset valid_out", 32'(valid_out), 32'd0);
      checkOutput("reset data_out", 32'(data_out), 32'd0);
      checkOutput("reset class_out", 32'(class_out), 32'd0);

      // Class 0 only: four reads, two-cycle latency.
      reset = 1'b0;
      waitDrain("class0 only", 40);
      checkOutput("class0 read count", 32'(rd0Cnt), 32'd4);
      checkOutput("class0 valid count", 32'(vCnt), 32'd4);
      checkOutput("read to valid latency", 32'(firstValid - firstRead), 32'd2);
      checkOutput("idle valid_out", 32'(valid_out), 32'd0);
      checkOutput("held data_out", 32'(data_out), 32'h0DD);

      // Contention: burst of 4 class-0 grants, then one class-1 grant.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 10'(i));
         applyStimulus(1'b1, 10'(10'h100 + i));
      end
      for (int i = 0; i < 4; i++) expectWord(1'b0, 10'(i));
      expectWord(1'b1, 10'h100);
      for (int i = 4; i < 8; i++) expectWord(1'b0, 10'(i));
      for (int i = 1; i < 8; i++) expectWord(1'b1, 10'(10'h100 + i));
      waitDrain("burst arbitration", 60);

      // Pause mid-stream for three cycles.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 10'(10'h0E0 + i));
         applyStimulus(1'b1, 10'(10'h0C0 + i));
      end
      for (int i = 0; i < 4; i++) expectWord(1'b0, 10'(10'h0E0 + i));
      expectWord(1'b1, 10'h0C0);
      expectWord(1'b0, 10'h0E4);
      expectWord(1'b0, 10'h0E5);
      for (int i = 1; i < 6; i++) expectWord(1'b1, 10'(10'h0C0 + i));
      repeat (3) @(negedge clk);
      r0 = rd0Cnt + rd1Cnt;
      pause_in = 1'b1;
      #1;
      checkOutput("pause blocks read0", 32'(read0), 32'd0);
      @(negedge clk);
      v0 = vCnt;
      repeat (2) @(negedge clk);
      checkOutput("reads during pause", 32'(rd0Cnt + rd1Cnt - r0), 32'd0);
      pause_in = 1'b0;
      @(negedge clk);
      checkOutput("in-flight words after pause", 32'(vCnt - v0), 32'd1);
      checkOutput("read resumes after pause", 32'(rd0Cnt + rd1Cnt - r0), 32'd1);
      waitDrain("pause stream", 60);

      // Class 1 only, then the FIFO runs empty.
      r1 = rd1Cnt;
      v0 = vCnt;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 10'h0BB);
         expectWord(1'b1, 10'h0BB);
      end
      waitDrain("class1 only", 40);
      checkOutput("class1 read count", 32'(rd1Cnt - r1), 32'd3);
      checkOutput("class1 valid count", 32'(vCnt - v0), 32'd3);
      checkOutput("class1 drained valid_out", 32'(valid_out), 32'd0);
      checkOutput("class1 state idle", 32'(dut.state_q), 32'd0);
      checkOutput("class_out after class1", 32'(class_out), 32'd1);

      // Reset while a read is in flight: the word must vanish.
      applyStimulus(1'b0, 10'h0AA);
      #1;
      checkOutput("reset-test read0", 32'(read0), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("read0 during reset", 32'(read0), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("post-reset valid_out", 32'(valid_out), 32'd0);
      checkOutput("post-reset data_out", 32'(data_out), 32'd0);
      checkOutput("post-reset class_out", 32'(class_out), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("discarded word stays gone", 32'(valid_out), 32'd0);

`ifdef VC_MERGE_COUNT_EN
      // Deliver 256 class-0 words so cnt0 wraps.
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b0, 10'(i));
         expectWord(1'b0, 10'(i));
      end
      waitDrain("counter wrap", 400);
      checkOutput("cnt0 wrapped", 32'(cnt0), 32'd0);
      checkOutput("cnt1 untouched", 32'(cnt1), 32'd0);
      checkOutput("cnt_ovf sticky", 32'(cnt_ovf), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("cnt0 after reset", 32'(cnt0), 32'd0);
      checkOutput("cnt1 after reset", 32'(cnt1), 32'd0);
      checkOutput("cnt_ovf after reset", 32'(cnt_ovf), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
